// File: rtl/mem_access.sv
// Data-memory access stage: one load/store per accepted op over a req/ack bus, result as a write-back or exception pulse.
// Zero-wait load-use latency 2 cycles; oReady drops while an access is in flight and inputs are ignored until it returns.
module mem_access #(
  parameter int pXLEN       = 32,
  parameter int pRegSelBitW = 5,
  parameter int pTimeout    = 255
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic [pXLEN-1:0]       iMemOpAddr,
  input  logic [pXLEN-1:0]       iMemOpData,
  input  logic [pRegSelBitW-1:0] iMemOpRdAddr,
  input  logic [2:0]             iMemOpType,
  input  logic                   iMemOpRead,
  input  logic                   iMemOpWrite,
  output logic                   oReady,
  output logic                   oMemReq,
  output logic                   oMemWe,
  output logic [pXLEN-1:0]       oMemAddr,
  output logic [pXLEN-1:0]       oMemWData,
  output logic [3:0]             oMemBe,
  input  logic                   iMemAck,
  input  logic [pXLEN-1:0]       iMemRData,
  output logic                   oRegDv,
  output logic [pRegSelBitW-1:0] oRegAddr,
  output logic [pXLEN-1:0]       oRegData,
  output logic                   oExcValid,
  output logic [1:0]             oExcCode,
  output logic [pXLEN-1:0]       oExcAddr
);

  localparam logic [1:0] sIdle = 2'd0;
  localparam logic [1:0] sBus  = 2'd1;
  localparam logic [1:0] sResp = 2'd2;

  localparam logic [1:0] cExcMisalign = 2'b01;
  localparam logic [1:0] cExcIllegal  = 2'b10;
  localparam logic [1:0] cExcTimeout  = 2'b11;

  localparam int              cCntW    = 10;
  localparam logic [cCntW-1:0] cCntLast = cCntW'(pTimeout - 1);

  typedef struct packed {
    logic                   isLoad;
    logic [2:0]             funct3;
    logic [pXLEN-1:0]       addr;
    logic [pRegSelBitW-1:0] rd;
  } memOp_t;

  logic [1:0]       state;
  logic [cCntW-1:0] cnt;
  memOp_t           op;

  logic             accept;
  logic             isLoad;
  logic             legal;
  logic             misaligned;
  logic [1:0]       offset;
  logic [3:0]       laneBe;
  logic [pXLEN-1:0] laneData;

  always_comb begin
    accept     = (state == sIdle) && (iMemOpRead || iMemOpWrite);
    isLoad     = iMemOpRead;
    offset     = iMemOpAddr[1:0];
    legal      = 1'b0;
    misaligned = 1'b0;
    laneBe     = 4'b1111;
    laneData   = iMemOpData;
    case (iMemOpType)
      3'b000: begin
        legal    = 1'b1;
        laneBe   = 4'b0001 << offset;
        laneData = {(pXLEN/8){iMemOpData[7:0]}};
      end
      3'b001: begin
        legal      = 1'b1;
        misaligned = offset[0];
        laneBe     = 4'b0011 << offset;
        laneData   = {(pXLEN/16){iMemOpData[15:0]}};
      end
      3'b010: begin
        legal      = 1'b1;
        misaligned = |offset;
      end
      3'b100: begin
        legal  = isLoad;
        laneBe = 4'b0001 << offset;
      end
      3'b101: begin
        legal      = isLoad;
        misaligned = offset[0];
        laneBe     = 4'b0011 << offset;
      end
      default: ;
    endcase
  end

  // Shifting the addressed lane down to bit 0 lets every load size share one extractor.
  logic [pXLEN-1:0] rShift;
  logic [pXLEN-1:0] loadData;

  always_comb begin
    rShift = iMemRData >> {op.addr[1:0], 3'b000};
    case (op.funct3)
      3'b000:  loadData = {{(pXLEN-8){rShift[7]}}, rShift[7:0]};
      3'b001:  loadData = {{(pXLEN-16){rShift[15]}}, rShift[15:0]};
      3'b100:  loadData = {{(pXLEN-8){1'b0}}, rShift[7:0]};
      3'b101:  loadData = {{(pXLEN-16){1'b0}}, rShift[15:0]};
      default: loadData = iMemRData;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= sIdle;
      cnt       <= '0;
      op        <= '0;
      oReady    <= 1'b1;
      oMemReq   <= 1'b0;
      oMemWe    <= 1'b0;
      oMemAddr  <= '0;
      oMemWData <= '0;
      oMemBe    <= '0;
      oRegDv    <= 1'b0;
      oRegAddr  <= '0;
      oRegData  <= '0;
      oExcValid <= 1'b0;
      oExcCode  <= '0;
      oExcAddr  <= '0;
    end else begin
      oRegDv    <= 1'b0;
      oExcValid <= 1'b0;
      case (state)
        sIdle: begin
          if (accept) begin
            if (!legal || misaligned) begin
              oExcValid <= 1'b1;
              oExcCode  <= legal ? cExcMisalign : cExcIllegal;
              oExcAddr  <= iMemOpAddr;
            end else begin
              state     <= sBus;
              cnt       <= '0;
              oReady    <= 1'b0;
              oMemReq   <= 1'b1;
              oMemWe    <= !isLoad;
              oMemAddr  <= {iMemOpAddr[pXLEN-1:2], 2'b00};
              oMemBe    <= laneBe;
              oMemWData <= isLoad ? '0 : laneData;
              op        <= '{isLoad: isLoad, funct3: iMemOpType,
                             addr: iMemOpAddr, rd: iMemOpRdAddr};
            end
          end
        end
        sBus: begin
          if (iMemAck) begin
            oMemReq <= 1'b0;
            if (op.isLoad) begin
              state    <= sResp;
              oRegDv   <= 1'b1;
              oRegAddr <= op.rd;
              oRegData <= loadData;
            end else begin
              state  <= sIdle;
              oReady <= 1'b1;
            end
          end else if (cnt == cCntLast) begin
            // The cycle that would bring the wait count to pTimeout abandons the access.
            state     <= sIdle;
            oReady    <= 1'b1;
            oMemReq   <= 1'b0;
            oExcValid <= 1'b1;
            oExcCode  <= cExcTimeout;
            oExcAddr  <= op.addr;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        sResp: begin
          state  <= sIdle;
          oReady <= 1'b1;
        end
        default: begin
          state  <= sIdle;
          oReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus randomized ops against a byte-level memory model.
module tb_mem_access;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int TMO  = 8;

  logic            iClk = 1'b0;
  logic            iRst;
  logic [XLEN-1:0] iMemOpAddr, iMemOpData, iMemRData;
  logic [RW-1:0]   iMemOpRdAddr;
  logic [2:0]      iMemOpType;
  logic            iMemOpRead, iMemOpWrite, iMemAck;
  logic            oReady, oMemReq, oMemWe, oRegDv, oExcValid;
  logic [XLEN-1:0] oMemAddr, oMemWData, oRegData, oExcAddr;
  logic [3:0]      oMemBe;
  logic [RW-1:0]   oRegAddr;
  logic [1:0]      oExcCode;

  always #5 iClk = ~iClk;

  mem_access #(.pXLEN(XLEN), .pRegSelBitW(RW), .pTimeout(TMO)) dut (
    .iClk(iClk), .iRst(iRst),
    .iMemOpAddr(iMemOpAddr), .iMemOpData(iMemOpData), .iMemOpRdAddr(iMemOpRdAddr),
    .iMemOpType(iMemOpType), .iMemOpRead(iMemOpRead), .iMemOpWrite(iMemOpWrite),
    .oReady(oReady), .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
    .oMemWData(oMemWData), .oMemBe(oMemBe), .iMemAck(iMemAck), .iMemRData(iMemRData),
    .oRegDv(oRegDv), .oRegAddr(oRegAddr), .oRegData(oRegData),
    .oExcValid(oExcValid), .oExcCode(oExcCode), .oExcAddr(oExcAddr)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] busMem [64];
  logic [7:0]  refMem [256];

  int          obsReqCycles, obsDvCount, obsExcCount, obsDvCycle, obsExcCycle, obsCycles;
  logic [31:0] obsReqAddr, obsReqWData, obsDvData, obsExcAddr;
  logic [3:0]  obsReqBe;
  logic        obsReqWe, obsUnstable, obsHung;
  logic [4:0]  obsDvAddr;
  logic [1:0]  obsExcCode;
  time         obsAcceptTime;

  task automatic set_word(input int w, input logic [31:0] val);
    busMem[w] = val;
    for (int b = 0; b < 4; b++) refMem[4*w+b] = val[8*b +: 8];
  endtask

  // Presents one op at the current negedge and plays memory until oReady returns.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] f3,
                        input logic [4:0] rdA, input int ackDelay);
    int  waitCnt;
    int  cyc;
    bit  done;
    obsReqCycles = 0; obsDvCount = 0; obsExcCount = 0; obsDvCycle = -1; obsExcCycle = -1;
    obsReqAddr = 'x; obsReqWData = 'x; obsReqBe = 'x; obsReqWe = 1'bx; obsUnstable = 1'b0;
    obsDvData = 'x; obsDvAddr = 'x; obsExcAddr = 'x; obsExcCode = 'x;
    waitCnt = 0;
    while (oReady !== 1'b1 && waitCnt < 50) begin
      @(negedge iClk);
      waitCnt++;
    end
    iMemOpRead = rd; iMemOpWrite = wr; iMemOpAddr = addr; iMemOpData = data;
    iMemOpType = f3; iMemOpRdAddr = rdA;
    @(negedge iClk);
    obsAcceptTime = $time;
    iMemOpRead = 1'b0; iMemOpWrite = 1'b0;
    cyc = 1; done = 0;
    while (!done && cyc <= 40) begin
      iMemAck   = 1'b0;
      iMemRData = $urandom;
      if (oMemReq === 1'b1) begin
        if (obsReqCycles == 0) begin
          obsReqAddr = oMemAddr; obsReqBe = oMemBe; obsReqWData = oMemWData; obsReqWe = oMemWe;
        end else if (oMemAddr !== obsReqAddr || oMemBe !== obsReqBe ||
                     oMemWData !== obsReqWData || oMemWe !== obsReqWe) begin
          obsUnstable = 1'b1;
        end
        obsReqCycles++;
        if (obsReqCycles == ackDelay + 1) begin
          iMemAck   = 1'b1;
          iMemRData = busMem[oMemAddr[7:2]];
          if (oMemWe === 1'b1)
            for (int b = 0; b < 4; b++)
              if (oMemBe[b]) busMem[oMemAddr[7:2]][8*b +: 8] = oMemWData[8*b +: 8];
        end
      end
      if (oRegDv === 1'b1) begin
        obsDvCount++; obsDvCycle = cyc; obsDvData = oRegData; obsDvAddr = oRegAddr;
      end
      if (oExcValid === 1'b1) begin
        obsExcCount++; obsExcCycle = cyc; obsExcCode = oExcCode; obsExcAddr = oExcAddr;
      end
      if (oReady === 1'b1 && oMemReq === 1'b0) begin
        done = 1;
      end else begin
        if (oReady === 1'b0) begin
          iMemOpRead = 1'($urandom_range(0, 1)); iMemOpWrite = 1'($urandom_range(0, 1));
          iMemOpAddr = $urandom; iMemOpData = $urandom;
          iMemOpType = 3'($urandom_range(0, 7)); iMemOpRdAddr = 5'($urandom_range(0, 31));
        end
        @(negedge iClk);
        iMemOpRead = 1'b0; iMemOpWrite = 1'b0;
        cyc++;
      end
    end
    iMemAck = 1'b0;
    iMemOpRead = 1'b0; iMemOpWrite = 1'b0;
    obsHung = !done;
    obsCycles = cyc;
  endtask

  task automatic test_reset;
    iRst = 1'b1; iMemAck = 1'b0; iMemRData = '0;
    iMemOpRead = 1'b0; iMemOpWrite = 1'b0; iMemOpAddr = '0; iMemOpData = '0;
    iMemOpType = '0; iMemOpRdAddr = '0;
    repeat (2) @(negedge iClk);
    total++; if (oReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", oReady); end
    total++; if (oMemReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", oMemReq); end
    total++; if ({oRegDv, oExcValid, oMemWe, oMemBe, oMemAddr, oExcCode} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {oRegDv, oExcValid, oMemWe, oMemBe, oMemAddr, oExcCode});
    end
    iRst = 1'b0;
    @(negedge iClk);
  endtask

  task automatic test_lw;
    set_word(0, 32'hDEADBEEF);
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 5'd7, 3);
    total++; if (obsReqAddr !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h exp=00000100", obsReqAddr); end
    total++; if (obsReqBe !== 4'b1111 || obsReqWe !== 1'b0) begin bad++; $display("FAIL lw_be_we got=%b/%b exp=1111/0", obsReqBe, obsReqWe); end
    total++; if (obsReqCycles !== 4) begin bad++; $display("FAIL lw_req_cycles got=%0d exp=4", obsReqCycles); end
    total++; if (obsDvCount !== 1 || obsDvData !== 32'hDEADBEEF || obsDvAddr !== 5'd7) begin
      bad++; $display("FAIL lw_wb got=%0d/%h/%0d exp=1/deadbeef/7", obsDvCount, obsDvData, obsDvAddr);
    end
    total++; if (obsDvCycle !== 5) begin bad++; $display("FAIL lw_dv_cycle got=%0d exp=5", obsDvCycle); end
  endtask

  task automatic test_sub_word_loads;
    set_word(0, 32'h80123456);
    run_op(1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 5'd1, 0);
    total++; if (obsDvData !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h exp=ffffff80", obsDvData); end
    total++; if (obsReqBe !== 4'b1000) begin bad++; $display("FAIL lb_be got=%b exp=1000", obsReqBe); end
    run_op(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 5'd2, 1);
    total++; if (obsDvData !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=00000080", obsDvData); end
    run_op(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 5'd3, 2);
    total++; if (obsDvData !== 32'hFFFF8012) begin bad++; $display("FAIL lh got=%h exp=ffff8012", obsDvData); end
    run_op(1'b1, 1'b0, 32'h102, 32'h0, 3'b101, 5'd0, 0);
    total++; if (obsDvData !== 32'h00008012 || obsDvAddr !== 5'd0 || obsDvCount !== 1) begin
      bad++; $display("FAIL lhu_rd0 got=%h/%0d/%0d exp=00008012/0/1", obsDvData, obsDvAddr, obsDvCount);
    end
  endtask

  task automatic test_stores;
    run_op(1'b0, 1'b1, 32'h22, 32'h1234ABCD, 3'b001, 5'd4, 1);
    refMem[8'h22] = 8'hCD; refMem[8'h23] = 8'hAB;
    total++; if (obsReqAddr !== 32'h20 || obsReqBe !== 4'b1100) begin
      bad++; $display("FAIL sh_addr_be got=%h/%b exp=00000020/1100", obsReqAddr, obsReqBe);
    end
    total++; if (obsReqWData !== 32'hABCDABCD || obsReqWe !== 1'b1) begin
      bad++; $display("FAIL sh_wdata got=%h/%b exp=abcdabcd/1", obsReqWData, obsReqWe);
    end
    total++; if (obsDvCount !== 0 || obsCycles !== 3) begin
      bad++; $display("FAIL sh_no_wb_ready got=%0d/%0d exp=0/3", obsDvCount, obsCycles);
    end
    run_op(1'b0, 1'b1, 32'h21, 32'h0000005A, 3'b000, 5'd0, 0);
    refMem[8'h21] = 8'h5A;
    total++; if (obsReqWData !== 32'h5A5A5A5A || obsReqBe !== 4'b0010) begin
      bad++; $display("FAIL sb got=%h/%b exp=5a5a5a5a/0010", obsReqWData, obsReqBe);
    end
  endtask

  task automatic test_exceptions;
    run_op(1'b1, 1'b0, 32'h102, 32'h0, 3'b010, 5'd5, 0);
    total++; if (obsExcCount !== 1 || obsExcCode !== 2'b01 || obsExcAddr !== 32'h102) begin
      bad++; $display("FAIL misalign got=%0d/%b/%h exp=1/01/00000102", obsExcCount, obsExcCode, obsExcAddr);
    end
    total++; if (obsReqCycles !== 0 || obsExcCycle !== 1 || obsDvCount !== 0) begin
      bad++; $display("FAIL misalign_nobus got=%0d/%0d/%0d exp=0/1/0", obsReqCycles, obsExcCycle, obsDvCount);
    end
    run_op(1'b0, 1'b1, 32'h30, 32'h55, 3'b100, 5'd0, 0);
    total++; if (obsExcCount !== 1 || obsExcCode !== 2'b10 || obsReqCycles !== 0) begin
      bad++; $display("FAIL illegal got=%0d/%b/%0d exp=1/10/0", obsExcCount, obsExcCode, obsReqCycles);
    end
  endtask

  task automatic test_timeout;
    run_op(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 5'd6, 1000);
    total++; if (obsReqCycles !== TMO) begin bad++; $display("FAIL timeout_req got=%0d exp=%0d", obsReqCycles, TMO); end
    total++; if (obsExcCount !== 1 || obsExcCode !== 2'b11 || obsExcAddr !== 32'h40) begin
      bad++; $display("FAIL timeout_exc got=%0d/%b/%h exp=1/11/00000040", obsExcCount, obsExcCode, obsExcAddr);
    end
    total++; if (obsExcCycle !== TMO + 1 || obsCycles !== TMO + 1 || obsHung !== 1'b0) begin
      bad++; $display("FAIL timeout_timing got=%0d/%0d/%b exp=%0d/%0d/0", obsExcCycle, obsCycles, obsHung, TMO + 1, TMO + 1);
    end
  endtask

  task automatic test_back_to_back;
    time t0;
    run_op(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 5'd1, 0);
    total++; if (obsDvCycle !== 2) begin bad++; $display("FAIL load_use got=%0d exp=2", obsDvCycle); end
    t0 = obsAcceptTime;
    run_op(1'b1, 1'b0, 32'h14, 32'h0, 3'b010, 5'd2, 0);
    total++; if (obsAcceptTime - t0 !== 30) begin bad++; $display("FAIL load_rate got=%0t exp=30", obsAcceptTime - t0); end
    run_op(1'b0, 1'b1, 32'h18, 32'h01020304, 3'b010, 5'd0, 0);
    for (int i = 0; i < 4; i++) refMem[8'h18 + i] = 8'(32'h01020304 >> (8*i));
    t0 = obsAcceptTime;
    run_op(1'b0, 1'b1, 32'h1C, 32'hA0B0C0D0, 3'b010, 5'd0, 0);
    for (int i = 0; i < 4; i++) refMem[8'h1C + i] = 8'(32'hA0B0C0D0 >> (8*i));
    total++; if (obsAcceptTime - t0 !== 20) begin bad++; $display("FAIL store_rate got=%0t exp=20", obsAcceptTime - t0); end
  endtask

  task automatic test_reset_mid_bus;
    logic sawActivity;
    iMemOpRead = 1'b1; iMemOpAddr = 32'h104; iMemOpType = 3'b010; iMemOpRdAddr = 5'd3;
    @(negedge iClk);
    iMemOpRead = 1'b0;
    total++; if (oMemReq !== 1'b1) begin bad++; $display("FAIL midrst_req got=%b exp=1", oMemReq); end
    @(negedge iClk);
    iRst = 1'b1;
    #1;
    total++; if (oMemReq !== 1'b0 || oReady !== 1'b1 || oMemAddr !== '0 || oMemBe !== '0) begin
      bad++; $display("FAIL midrst_async got=%b/%b/%h/%b exp=0/1/0/0", oMemReq, oReady, oMemAddr, oMemBe);
    end
    @(negedge iClk);
    iRst = 1'b0; iMemAck = 1'b1; iMemRData = 32'h11111111;
    @(negedge iClk);
    iMemAck = 1'b0;
    sawActivity = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (oRegDv !== 1'b0 || oMemReq !== 1'b0 || oExcValid !== 1'b0) sawActivity = 1'b1;
      @(negedge iClk);
    end
    total++; if (sawActivity !== 1'b0) begin bad++; $display("FAIL late_ack got=%b exp=0", sawActivity); end
    set_word(1, 32'hCAFEF00D);
    run_op(1'b1, 1'b0, 32'h104, 32'h0, 3'b010, 5'd9, 1);
    total++; if (obsDvCount !== 1 || obsDvData !== 32'hCAFEF00D || obsDvAddr !== 5'd9) begin
      bad++; $display("FAIL after_rst_load got=%0d/%h/%0d exp=1/cafef00d/9", obsDvCount, obsDvData, obsDvAddr);
    end
  endtask

  task automatic test_random;
    logic        rd, wr, isLoad, legal;
    logic [31:0] addr, data, expV;
    logic [2:0]  f3;
    logic [4:0]  rdA;
    logic [3:0]  expBe;
    logic [1:0]  expExc;
    int          ackDelay, n;
    for (int it = 0; it < 80; it++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      data = $urandom;
      f3 = 3'($urandom_range(0, 7));
      rdA = 5'($urandom_range(0, 31));
      ackDelay = $urandom_range(0, 4);
      run_op(rd, wr, addr, data, f3, rdA, ackDelay);

      isLoad = rd;
      legal = isLoad ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
      n = 1 << f3[1:0];
      expExc = !legal ? 2'b10 : ((int'(addr[1:0]) % n) != 0) ? 2'b01 : 2'b00;
      if (expExc != 2'b00) begin
        total++; if (obsExcCount !== 1 || obsExcCode !== expExc || obsExcAddr !== addr || obsReqCycles !== 0 || obsDvCount !== 0) begin
          bad++; $display("FAIL rnd_exc it=%0d got=%0d/%b/%h/%0d/%0d exp=1/%b/%h/0/0", it, obsExcCount, obsExcCode, obsExcAddr, obsReqCycles, obsDvCount, expExc, addr);
        end
      end else begin
        expBe = '0;
        for (int i = 0; i < n; i++) expBe[int'(addr[1:0]) + i] = 1'b1;
        total++; if (obsReqCycles !== ackDelay + 1 || obsReqAddr !== {addr[31:2], 2'b00} || obsReqBe !== expBe ||
                     obsReqWe !== !isLoad || obsUnstable !== 1'b0 || obsExcCount !== 0) begin
          bad++; $display("FAIL rnd_bus it=%0d got=%0d/%h/%b/%b/%b/%0d exp=%0d/%h/%b/%b/0/0", it, obsReqCycles, obsReqAddr, obsReqBe, obsReqWe, obsUnstable, obsExcCount, ackDelay + 1, {addr[31:2], 2'b00}, expBe, !isLoad);
        end
        if (isLoad) begin
          expV = '0;
          for (int i = 0; i < n; i++) expV = expV | (32'(refMem[(int'(addr[7:0]) + i) & 255]) << (8*i));
          if (!f3[2] && n < 4 && expV[8*n-1]) expV = expV | (32'hFFFFFFFF << (8*n));
          total++; if (obsDvCount !== 1 || obsDvData !== expV || obsDvAddr !== rdA || obsDvCycle !== ackDelay + 2 || obsCycles !== ackDelay + 3) begin
            bad++; $display("FAIL rnd_load it=%0d got=%0d/%h/%0d/%0d/%0d exp=1/%h/%0d/%0d/%0d", it, obsDvCount, obsDvData, obsDvAddr, obsDvCycle, obsCycles, expV, rdA, ackDelay + 2, ackDelay + 3);
          end
        end else begin
          for (int i = 0; i < n; i++) refMem[(int'(addr[7:0]) + i) & 255] = 8'(data >> (8*i));
          total++; if (obsDvCount !== 0 || obsCycles !== ackDelay + 2) begin
            bad++; $display("FAIL rnd_store it=%0d got=%0d/%0d exp=0/%0d", it, obsDvCount, obsCycles, ackDelay + 2);
          end
        end
      end
    end
  endtask

  task automatic test_memory_image;
    logic [31:0] expW;
    for (int w = 0; w < 64; w++) begin
      expW = {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]};
      total++; if (busMem[w] !== expW) begin bad++; $display("FAIL mem_word w=%0d got=%h exp=%h", w, busMem[w], expW); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 64; w++) set_word(w, $urandom);
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_stores();
    test_exceptions();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    test_random();
    test_memory_image();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
